// File: rtl/cordic_pkg.sv
// cordic_pkg
//   Shared definitions for the CORDIC engines (vectoring and rotation).
//   Angle format: full circle = 65536, bits [15:14] select the quadrant.
//   Contents: angle/internal widths, CORDIC gain correction constant,
//   half-circle angle, vectoring FSM state enum and the arctangent table.
package cordic_pkg;

    localparam int ANGLE_W = 16;
    localparam int INT_W   = 18;

    // 1/K for the shift-add gain, 0.607253 * 2^15.
    localparam logic [ANGLE_W-1:0] KN       = 16'd19898;
    localparam logic [ANGLE_W-1:0] PI_ANGLE = 16'd32768;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ITER  = 2'd1,
        ST_SCALE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // round(atan(2^-i) * 32768 / pi); indices past the table return 0.
    function automatic logic [ANGLE_W-1:0] atan_lookup(input logic [3:0] idx);
        logic [ANGLE_W-1:0] val;
        case (idx)
            4'd0:    val = 16'd8192;
            4'd1:    val = 16'd4836;
            4'd2:    val = 16'd2555;
            4'd3:    val = 16'd1297;
            4'd4:    val = 16'd651;
            4'd5:    val = 16'd326;
            4'd6:    val = 16'd163;
            4'd7:    val = 16'd81;
            4'd8:    val = 16'd41;
            4'd9:    val = 16'd20;
            4'd10:   val = 16'd10;
            4'd11:   val = 16'd5;
            4'd12:   val = 16'd3;
            4'd13:   val = 16'd1;
            default: val = 16'd0;
        endcase
        return val;
    endfunction

endpackage

// File: rtl/cordic_atan_lut.sv
// cordic_atan_lut
//   Combinational micro-rotation angle lookup.
//   Ports:
//     idx      in  4   micro-rotation index
//     atan_val out 16  atan(2^-idx) in the shared angle format
module cordic_atan_lut
    import cordic_pkg::*;
(
    input  logic [3:0]         idx,
    output logic [ANGLE_W-1:0] atan_val
);

    always_comb begin
        atan_val = atan_lookup(idx);
    end

endmodule

// File: rtl/cordic_vectoring.sv
// cordic_vectoring
//   Iterative CORDIC vectoring engine: (x, y) -> (angle, magnitude).
//   A single shift-add datapath performs ITER micro-rotations, then one
//   cycle scales the magnitude by 1/K and latches the result.
//   Ports:
//     clk, rst_n           clock, asynchronous active-low reset
//     in_valid / in_ready  input handshake (in_ready high only when idle)
//     x_in, y_in           signed 16-bit Cartesian input
//     out_valid/out_ready  output handshake (out_valid high in DONE)
//     angle                phase, 0..65535 <-> 0..<2*pi
//     magnitude            sqrt(x^2+y^2), gain corrected, saturating
module cordic_vectoring
    import cordic_pkg::*;
#(
    parameter int ITER = 14
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic signed [15:0]  x_in,
    input  logic signed [15:0]  y_in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [ANGLE_W-1:0]  angle,
    output logic [ANGLE_W-1:0]  magnitude
);

    localparam int         PROD_W   = INT_W + ANGLE_W;
    localparam logic [3:0] LAST_CNT = 4'(ITER - 1);

    state_e                    state_q, state_d;
    logic [3:0]                cnt_q, cnt_d;
    logic signed [INT_W-1:0]   x_q, x_d;
    logic signed [INT_W-1:0]   y_q, y_d;
    logic [ANGLE_W-1:0]        z_q, z_d;
    logic                      zero_q, zero_d;
    logic [ANGLE_W-1:0]        angle_q, angle_d;
    logic [ANGLE_W-1:0]        mag_q, mag_d;

    logic signed [INT_W-1:0]   x_ext, y_ext;
    logic signed [INT_W-1:0]   x_sh, y_sh;
    logic [ANGLE_W-1:0]        atan_val;
    logic [PROD_W-1:0]         prod;

    // Drop the Q15 fraction and clamp to the 16-bit output range.
    function automatic logic [ANGLE_W-1:0] sat_mag(input logic [PROD_W-1:0] p);
        logic [PROD_W-1:0] s;
        s = p >> 15;
        if (s > PROD_W'(16'hFFFF)) begin
            return 16'hFFFF;
        end
        return s[ANGLE_W-1:0];
    endfunction

    cordic_atan_lut u_atan_lut (
        .idx      (cnt_q),
        .atan_val (atan_val)
    );

    assign x_ext = {{(INT_W-16){x_in[15]}}, x_in};
    assign y_ext = {{(INT_W-16){y_in[15]}}, y_in};
    assign x_sh  = x_q >>> cnt_q;
    assign y_sh  = y_q >>> cnt_q;

    // x is non-negative after the half-plane fold, so an unsigned product is exact.
    assign prod = {{ANGLE_W{1'b0}}, x_q} * {{INT_W{1'b0}}, KN};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        zero_d  = zero_q;
        angle_d = angle_q;
        mag_d   = mag_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    state_d = ST_ITER;
                    cnt_d   = 4'd0;
                    zero_d  = (x_in == 16'sd0) && (y_in == 16'sd0);
                    // Fold the left half-plane onto the right by a pi rotation.
                    if (x_in[15]) begin
                        x_d = -x_ext;
                        y_d = -y_ext;
                        z_d = PI_ANGLE;
                    end else begin
                        x_d = x_ext;
                        y_d = y_ext;
                        z_d = '0;
                    end
                end
            end

            ST_ITER: begin
                if (!y_q[INT_W-1]) begin
                    x_d = x_q + y_sh;
                    y_d = y_q - x_sh;
                    z_d = z_q + atan_val;
                end else begin
                    x_d = x_q - y_sh;
                    y_d = y_q + x_sh;
                    z_d = z_q - atan_val;
                end
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == LAST_CNT) begin
                    state_d = ST_SCALE;
                end
            end

            ST_SCALE: begin
                if (zero_q) begin
                    angle_d = '0;
                    mag_d   = '0;
                end else begin
                    angle_d = z_q;
                    mag_d   = sat_mag(prod);
                end
                state_d = ST_DONE;
            end

            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            zero_q  <= 1'b0;
            angle_q <= '0;
            mag_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            zero_q  <= zero_d;
            angle_q <= angle_d;
            mag_q   <= mag_d;
        end
    end

    // in_ready is forced low while reset is held.
    assign in_ready  = rst_n && (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign angle     = angle_q;
    assign magnitude = mag_q;

endmodule

// File: tb/tb_cordic_vectoring.sv
// tb_cordic_vectoring
//   Bench for cordic_vectoring: a vector table pushed through a scoreboard
//   queue, plus hand-written latency, backpressure and reset sequences.
module tb_cordic_vectoring;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic signed [15:0] x_in;
    logic signed [15:0] y_in;
    logic               out_valid;
    logic               out_ready;
    logic [15:0]        angle;
    logic [15:0]        magnitude;

    always #5 clk = ~clk;

    cordic_vectoring #(.ITER(14)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x_in      (x_in),
        .y_in      (y_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .angle     (angle),
        .magnitude (magnitude)
    );

    typedef struct {
        int x;
        int y;
        int exp_ang;
        int exp_mag;
        int ang_tol;
        int mag_tol;
    } vec_t;

    vec_t sb[$];
    vec_t tbl[11];
    vec_t mon_e;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input int act, input int exp, input int tol,
                       input bit is_angle);
        int d;
        checks++;
        d = act - exp;
        if (is_angle) begin
            d = ((d % 65536) + 65536) % 65536;
            if (d > 32767) d = d - 65536;
        end
        if (d < 0) d = -d;
        if (d > tol) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (tol %0d)", name, act, exp, tol);
        end
    endtask

    function automatic vec_t lit(input int x, input int y, input int ea, input int em,
                                 input int at, input int mt);
        vec_t v;
        v.x = x; v.y = y; v.exp_ang = ea; v.exp_mag = em; v.ang_tol = at; v.mag_tol = mt;
        return v;
    endfunction

    // Reference from real arithmetic: phase in 65536ths of a turn, Euclidean norm.
    function automatic vec_t mk(input int x, input int y, input int at, input int mt);
        vec_t v;
        real  a, m;
        a = $atan2(real'(y), real'(x)) * 32768.0 / 3.14159265358979;
        if (a < 0.0) a = a + 65536.0;
        m = $sqrt(real'(x) * real'(x) + real'(y) * real'(y));
        v.x = x; v.y = y; v.ang_tol = at; v.mag_tol = mt;
        v.exp_ang = int'(a);
        if (v.exp_ang >= 65536) v.exp_ang = v.exp_ang - 65536;
        v.exp_mag = int'(m);
        if (v.exp_mag > 65535) v.exp_mag = 65535;
        return v;
    endfunction

    // Scoreboard: every output handshake is checked against the oldest accepted vector.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got angle=%0d mag=%0d, expected no output",
                         angle, magnitude);
            end else begin
                mon_e = sb.pop_front();
                chk($sformatf("angle(%0d,%0d)", mon_e.x, mon_e.y), int'(angle),
                    mon_e.exp_ang, mon_e.ang_tol, 1'b1);
                chk($sformatf("magnitude(%0d,%0d)", mon_e.x, mon_e.y), int'(magnitude),
                    mon_e.exp_mag, mon_e.mag_tol, 1'b0);
            end
        end
    end

    // Drive one vector and wait for its accept edge; returns #1 after that edge.
    task automatic send(input vec_t v);
        int n;
        x_in     = 16'(v.x);
        y_in     = 16'(v.y);
        in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got in_ready=0, expected 1 within 100 cycles");
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        sb.push_back(v);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending results, expected 0", sb.size());
            sb.delete();
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n, k, first_ov, second_ov, first_ir, changes;
        bit   prev_ov;
        logic [15:0] a0, m0;
        vec_t va, vb, vc, vd;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; x_in = '0; y_in = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_in_ready", int'(in_ready), 0, 0, 1'b0);
        chk("reset_out_valid", int'(out_valid), 0, 0, 1'b0);
        chk("reset_angle", int'(angle), 0, 0, 1'b0);
        chk("reset_magnitude", int'(magnitude), 0, 0, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("idle_in_ready", int'(in_ready), 1, 0, 1'b0);

        tbl[0]  = lit( 16384,      0,     0, 16384, 2,  8);
        tbl[1]  = lit(     0,  16384, 16384, 16384, 2,  8);
        tbl[2]  = lit(-16384,      0, 32768, 16384, 2,  8);
        tbl[3]  = lit(     0, -16384, 49152, 16384, 2,  8);
        tbl[4]  = lit(-32768, -32768, 40960, 46341, 2, 16);
        tbl[5]  = lit( 32767,  32767,  8192, 46340, 2, 16);
        tbl[6]  = lit(     0,      0,     0,     0, 0,  0);
        tbl[7]  = mk( 10000, -20000, 5, 16);
        tbl[8]  = mk(-25000,  12000, 5, 16);
        tbl[9]  = mk( -5000, -30000, 5, 16);
        tbl[10] = mk( 30000,    -30, 5, 16);

        @(posedge clk);
        #1 out_ready = 1'b1;
        for (int i = 0; i < 11; i++) begin
            send(tbl[i]);
            wait_drain();
        end

        // Latency and throughput with in_valid held and out_ready high.
        va = mk(12000, 5000, 5, 16);
        x_in = 16'(va.x); y_in = 16'(va.y); in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        sb.push_back(va);
        sb.push_back(va);
        #1;
        first_ov = 0; second_ov = 0; first_ir = 0; prev_ov = 1'b0;
        for (k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (out_valid && !prev_ov) begin
                if (first_ov == 0) first_ov = k;
                else if (second_ov == 0) second_ov = k;
            end
            prev_ov = out_valid;
            if (in_ready && first_ir == 0) begin
                first_ir = k;
                @(posedge clk);
                #1 in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        chk("latency_cycles", first_ov - 1, 15, 0, 1'b0);
        chk("busy_cycles", first_ir - 1, 16, 0, 1'b0);
        chk("result_spacing", second_ov - first_ov, 17, 0, 1'b0);
        wait_drain();

        // Backpressure: hold DONE for 10 cycles with a pending input waiting.
        vb = mk(-9000, 21000, 5, 16);
        vc = mk(15000, -4000, 5, 16);
        out_ready = 1'b0;
        send(vb);
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("bp_out_valid_rise", int'(out_valid), 1, 0, 1'b0);
        a0 = angle; m0 = magnitude; changes = 0;
        @(posedge clk);
        #1;
        x_in = 16'(vc.x); y_in = 16'(vc.y); in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("bp_out_valid", int'(out_valid), 1, 0, 1'b0);
            chk("bp_in_ready", int'(in_ready), 0, 0, 1'b0);
            chk("bp_angle", int'(angle), vb.exp_ang, vb.ang_tol, 1'b1);
            chk("bp_magnitude", int'(magnitude), vb.exp_mag, vb.mag_tol, 1'b0);
            if (angle != a0 || magnitude != m0) changes++;
        end
        chk("bp_output_changes", changes, 0, 0, 1'b0);
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        sb.push_back(vc);
        @(negedge clk);
        chk("bp_single_handshake", int'(out_valid), 0, 0, 1'b0);
        chk("bp_ready_after_handshake", int'(in_ready), 1, 0, 1'b0);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        chk("held_input_accepted", int'(in_ready), 0, 0, 1'b0);
        out_ready = 1'b1;
        wait_drain();

        // Reset during iteration 5 discards the in-flight result.
        vd = mk(-20000, 9000, 5, 16);
        send(vd);
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_out_valid", int'(out_valid), 0, 0, 1'b0);
        chk("abort_angle", int'(angle), 0, 0, 1'b0);
        chk("abort_magnitude", int'(magnitude), 0, 0, 1'b0);
        chk("abort_in_ready", int'(in_ready), 0, 0, 1'b0);
        sb.delete();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        n = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (out_valid) n++;
        end
        chk("abort_no_out_valid", n, 0, 0, 1'b0);
        @(posedge clk);
        #1;
        send(lit(3000, 4000, 9672, 5000, 2, 4));
        wait_drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
